div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Sits between the execute stage and the multi-cycle restoring divider (RV32M DIV/DIVU/REM/REMU).
- Accepts one request at a time and drives the divider's start/op/operand interface. Holds the operands stable until the divider reports finished.
- Reads back both quotient and remainder by switching div_op for one cycle, then stores them in a one-entry result cache so that a following DIV/REM pair on the same operands completes in 1 cycle.
- Handles pipeline flush by draining the un-abortable divider.

Parameters:
- CACHE_EN, 1, 1 enables the one-entry quotient/remainder cache; 0 forces every legal op through the divider.
- TAG_W, 5, width of the destination-register tag carried with the request.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  execute stage presents a divide op
- req_ready  out  1  sequencer accepts the op this cycle
- req_op  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_rs1  in  32  numerator
- req_rs2  in  32  denominator
- req_rd  in  TAG_W  destination tag
- flush  in  1  kill any accepted, not-yet-responded op
- resp_valid  out  1  one-cycle result pulse; no backpressure
- resp_data  out  32  result
- resp_rd  out  TAG_W  tag of the result
- div_start  out  1  to divider start
- div_op  out  3  to divider div_op
- div_dividend  out  32  to divider dividend (numerator)
- div_divisor  out  32  to divider divisor (denominator)
- div_result  in  32  from divider result (combinational on div_op)
- div_busy  in  1  from divider busy
- div_finished  in  1  from divider finished (one-cycle pulse)

Behaviour:
- Reset: state IDLE; cache_valid=0; resp_valid=0, req_ready=0, div_start=0; div_op=100; operand registers=0.
  - The divider has no reset and may still be busy after reset. The sequencer does not accept a request while div_busy=1.
- req_ready = (state==IDLE) && !div_busy && !flush. Accept = req_valid && req_ready.
- The sequencer latches op, rs1, rs2 and rd on accept.
  - alt_op = op ^ 3'b010 (DIV<->REM, DIVU<->REMU).
  - signedness = !op[0].
- Cache hit: CACHE_EN && cache_valid && rs1, rs2 and signedness equal to the cached values.
- States and transitions:
  - IDLE: on accept with req_op[2]==0 (illegal) -> HIT with data 0. On accept with a hit -> HIT with data = cached quotient if op[1]==0, else cached remainder. Any other accept -> ISSUE.
  - HIT: resp_valid=1 for one cycle -> IDLE. The divider is untouched.
  - ISSUE: div_start=1, div_op=op, operands driven from the latched registers. -> WAIT at the edge where div_busy==0, i.e. the divider samples start. flush in ISSUE: div_start forced to 0 -> IDLE.
  - WAIT: operands and div_op held. On div_finished: capture div_result as primary -> CAPT. flush -> DRAIN.
  - CAPT: div_op=alt_op; capture div_result as alternate; resp_valid=1 with primary. Fill the cache with {rs1, rs2, signedness, quotient, remainder}, mapped from primary/alternate by op[1]; cache_valid=1. -> IDLE.
  - DRAIN: operands held; on div_finished -> IDLE. No response, no cache fill.
- flush in CAPT or HIT: resp_valid gated to 0 that cycle; the CAPT cache fill still occurs, because the results depend only on the operands.
- resp_valid = (state==HIT || state==CAPT) && !flush. resp_rd is the latched tag.
- Latency:
  - Hit or illegal op: accept at T, resp at T+1.
  - Miss: start at T+1; resp 1 cycle after div_finished.
- Division by zero and signed overflow results come from the divider unchanged and are cached like any other result.
- The operand registers change only on accept. div_dividend and div_divisor are stable from ISSUE through CAPT/DRAIN.

Test Plan:
- DIV rs1=100, rs2=7 -> div_start pulses once; resp_data=14, resp_rd=tag, 1 cycle after div_finished. Then REM 100,7 -> resp_data=2 at T+1, div_start stays low.
- DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. Then DIV with the same operands -> cache miss (signedness differs), divider runs, result 0.
- DIV -20/3 -> 0xFFFFFFFA (-6); REM same -> 0xFFFFFFFE (-2) from the cache. DIV x/0 -> 0xFFFFFFFF; REM x/0 -> x.
- flush 5 cycles into WAIT -> no resp_valid; req_ready=0 until div_finished, then 1. Next request starts cleanly.
- rst_n low for 1 cycle mid-divide -> cache_valid=0, IDLE, req_ready=0 while div_busy=1; the first post-reset request is served correctly.
- req_op=3'b010 -> resp_data=0 at T+1, no div_start. req_valid held with flush=1 -> not accepted.

Source files
------------

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : div_sequencer
//  Description : Sequences RV32M DIV/DIVU/REM/REMU requests onto a multi-cycle
//                restoring divider. Reads back quotient and remainder, keeps
//                them in a one-entry cache, and drains the divider on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer #(
    parameter bit CACHE_EN = 1'b1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_rd,
    input  logic             flush,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_rd,
    output logic             div_start,
    output logic [2:0]       div_op,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    input  logic [31:0]      div_result,
    input  logic             div_busy,
    input  logic             div_finished
);

    localparam logic [2:0] OP_DIV = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIT   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CAPT  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic [TAG_W-1:0]   rd_q, rd_d;
    logic [31:0]        data_q, data_d;      // response data (hit value or primary result)
    logic               cache_valid_q, cache_valid_d;
    logic [31:0]        cache_rs1_q, cache_rs1_d;
    logic [31:0]        cache_rs2_q, cache_rs2_d;
    logic               cache_sgn_q, cache_sgn_d;
    logic [31:0]        cache_quo_q, cache_quo_d;
    logic [31:0]        cache_rem_q, cache_rem_d;

    logic               accept;
    logic               cache_hit;

    assign resp_data    = data_q;
    assign resp_rd      = rd_q;
    assign div_dividend = rs1_q;
    assign div_divisor  = rs2_q;

    // Next-state, datapath capture and handshake outputs
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        data_d        = data_q;
        cache_valid_d = cache_valid_q;
        cache_rs1_d   = cache_rs1_q;
        cache_rs2_d   = cache_rs2_q;
        cache_sgn_d   = cache_sgn_q;
        cache_quo_d   = cache_quo_q;
        cache_rem_d   = cache_rem_q;
        resp_valid    = 1'b0;
        div_start     = 1'b0;
        div_op        = OP_DIV;

        req_ready = rst_n && (state_q == S_IDLE) && !div_busy && !flush;
        accept    = req_valid && req_ready;
        // Signedness (not DIV vs REM) is the key: one divide yields both results.
        cache_hit = CACHE_EN && cache_valid_q &&
                    (req_rs1 == cache_rs1_q) && (req_rs2 == cache_rs2_q) &&
                    (!req_op[0] == cache_sgn_q);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = req_op;
                    rs1_d = req_rs1;
                    rs2_d = req_rs2;
                    rd_d  = req_rd;
                    if (!req_op[2]) begin
                        data_d  = 32'd0;
                        state_d = S_HIT;
                    end else if (cache_hit) begin
                        data_d  = req_op[1] ? cache_rem_q : cache_quo_q;
                        state_d = S_HIT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_HIT: begin
                resp_valid = !flush;
                state_d    = S_IDLE;
            end
            S_ISSUE: begin
                div_op = op_q;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    div_start = 1'b1;
                    if (!div_busy) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                div_op = op_q;
                if (div_finished) begin
                    // A flush coinciding with finish has nothing left to drain.
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = div_result;
                        state_d = S_CAPT;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_CAPT: begin
                // Flipping div_op exposes the companion result for this cycle only.
                div_op        = op_q ^ 3'b010;
                resp_valid    = !flush;
                cache_valid_d = 1'b1;
                cache_rs1_d   = rs1_q;
                cache_rs2_d   = rs2_q;
                cache_sgn_d   = !op_q[0];
                cache_quo_d   = op_q[1] ? div_result : data_q;
                cache_rem_d   = op_q[1] ? data_q : div_result;
                state_d       = S_IDLE;
            end
            S_DRAIN: begin
                div_op = op_q;
                if (div_finished) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!rst_n) begin
            resp_valid = 1'b0;
            div_start  = 1'b0;
            div_op     = OP_DIV;
        end
    end

    // State, request latches and result cache registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= OP_DIV;
            rs1_q         <= 32'd0;
            rs2_q         <= 32'd0;
            rd_q          <= '0;
            data_q        <= 32'd0;
            cache_valid_q <= 1'b0;
            cache_rs1_q   <= 32'd0;
            cache_rs2_q   <= 32'd0;
            cache_sgn_q   <= 1'b0;
            cache_quo_q   <= 32'd0;
            cache_rem_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            data_q        <= data_d;
            cache_valid_q <= cache_valid_d;
            cache_rs1_q   <= cache_rs1_d;
            cache_rs2_q   <= cache_rs2_d;
            cache_sgn_q   <= cache_sgn_d;
            cache_quo_q   <= cache_quo_d;
            cache_rem_q   <= cache_rem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_sequencer
//  Description : Self-checking bench for div_sequencer with a behavioural
//                divider and a transaction-timeline reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = 3'b100;
    logic [31:0]      req_rs1 = 32'd0;
    logic [31:0]      req_rs2 = 32'd0;
    logic [TAG_W-1:0] req_rd = '0;
    logic             flush = 1'b0;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_rd;
    logic             div_start;
    logic [2:0]       div_op;
    logic [31:0]      div_dividend;
    logic [31:0]      div_divisor;
    logic [31:0]      div_result;
    logic             dv_busy = 1'b0;
    logic             dv_fin = 1'b0;

    div_sequencer #(.CACHE_EN(1'b1), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .div_start(div_start), .div_op(div_op),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_result(div_result), .div_busy(dv_busy), .div_finished(dv_fin)
    );

    always #5 clk = ~clk;

    // RV32M divide semantics from the ISA rules
    function automatic logic [31:0] rv_div(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Behavioural divider: no reset, samples start when idle, result follows div_op
    int          dv_cnt = 0;
    logic [31:0] dv_a = 32'd0;
    logic [31:0] dv_b = 32'd0;
    assign div_result = rv_div(div_op, dv_a, dv_b);

    always @(posedge clk) begin
        dv_fin <= 1'b0;
        if (dv_busy) begin
            if (dv_cnt <= 1) begin
                dv_busy <= 1'b0;
                dv_fin  <= 1'b1;
            end
            dv_cnt <= dv_cnt - 1;
        end else if (div_start) begin
            dv_busy <= 1'b1;
            dv_cnt  <= int'($urandom_range(8, 12));
            dv_a    <= div_dividend;
            dv_b    <= div_divisor;
        end
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int resp_cnt = 0;
    int start_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one outstanding transaction on a cycle timeline
    int               t_resp = -1;   // cycle in which the response is due
    int               t_start = -1;  // cycle in which div_start is due
    int               t_free = 0;    // first cycle the sequencer can accept again
    bit               m_wait = 1'b0; // transaction owns the running divider
    bit               m_live = 1'b0; // response still owed
    logic [2:0]       m_op;
    logic [31:0]      m_a, m_b, m_data;
    logic [TAG_W-1:0] m_rd;
    bit               mc_ok = 1'b0;
    logic [31:0]      mc_a, mc_b;
    bit               mc_s;
    bit               e_ready, e_resp, e_start, fast;

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
            chk("rst_div_start",  {31'd0, div_start},  32'd0);
            mc_ok = 1'b0; m_wait = 1'b0; m_live = 1'b0;
            t_resp = -1; t_start = -1; t_free = 0;
        end else begin
            e_ready = !((cyc < t_free) || m_wait) && !dv_busy && !flush;
            e_resp  = (cyc == t_resp) && !flush;
            e_start = (cyc == t_start) && !flush;
            chk("req_ready",  {31'd0, req_ready},  {31'd0, e_ready});
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_resp});
            chk("div_start",  {31'd0, div_start},  {31'd0, e_start});
            if (e_resp) begin
                chk("resp_data", resp_data, m_data);
                chk("resp_rd", {27'd0, resp_rd}, {27'd0, m_rd});
            end
            if (m_wait && dv_busy) begin
                chk("hold_dividend", div_dividend, m_a);
                chk("hold_divisor",  div_divisor,  m_b);
                chk("hold_div_op",   {29'd0, div_op}, {29'd0, m_op});
            end
            if (cyc == t_start) begin
                if (flush) t_free = cyc + 1;
                else begin m_wait = 1'b1; m_live = 1'b1; end
            end else if (m_wait) begin
                if (dv_fin) begin
                    m_wait = 1'b0;
                    if (m_live && !flush) begin
                        t_resp = cyc + 1;
                        t_free = cyc + 2;
                        mc_ok = 1'b1; mc_a = m_a; mc_b = m_b; mc_s = !m_op[0];
                    end else begin
                        t_free = cyc + 1;
                    end
                end else if (flush) begin
                    m_live = 1'b0;
                end
            end
            if (req_valid && e_ready) begin
                m_op = req_op; m_a = req_rs1; m_b = req_rs2; m_rd = req_rd;
                m_data = req_op[2] ? rv_div(req_op, req_rs1, req_rs2) : 32'd0;
                fast = !req_op[2] || (mc_ok && mc_a == req_rs1 && mc_b == req_rs2 &&
                                      mc_s == !req_op[0]);
                if (fast) t_resp = cyc + 1;
                else t_start = cyc + 1;
                t_free = cyc + 2;
            end
        end
        if (resp_valid) resp_cnt++;
        if (div_start) start_cnt++;
        cyc++;
    end

    // Issue one request and wait for its response
    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] rd, output logic [31:0] data,
                          output int lat, output int starts);
        int k;
        int s0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 60) begin @(negedge clk); k++; end
        if (!req_ready) chk("accept_timeout", 32'd1, 32'd0);
        s0 = start_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 60);
        if (!resp_valid) chk("resp_timeout", 32'd1, 32'd0);
        data = resp_data;
        starts = start_cnt - s0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] d;
    int          lat, st, k, r0;
    logic [31:0] pool [8];
    logic [31:0] la, lb;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_div_op",   {29'd0, div_op}, 32'd4);
        chk("rst_dividend", div_dividend, 32'd0);
        chk("rst_divisor",  div_divisor,  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        do_req(3'b100, 32'd100, 32'd7, 5'd3, d, lat, st);
        chk("div_100_7", d, 32'd14);
        chk("div_100_7_starts", st, 1);
        chk("div_100_7_rd", {27'd0, resp_rd}, 32'd3);
        do_req(3'b110, 32'd100, 32'd7, 5'd4, d, lat, st);
        chk("rem_100_7", d, 32'd2);
        chk("rem_100_7_lat", lat, 1);
        chk("rem_100_7_starts", st, 0);

        do_req(3'b101, 32'hFFFF_FFFF, 32'd2, 5'd5, d, lat, st);
        chk("divu_max_2", d, 32'h7FFF_FFFF);
        do_req(3'b100, 32'hFFFF_FFFF, 32'd2, 5'd6, d, lat, st);
        chk("div_m1_2", d, 32'd0);
        chk("div_m1_2_starts", st, 1);

        do_req(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd7, d, lat, st);
        chk("div_m20_3", d, 32'hFFFF_FFFA);
        do_req(3'b110, 32'hFFFF_FFEC, 32'd3, 5'd8, d, lat, st);
        chk("rem_m20_3", d, 32'hFFFF_FFFE);
        chk("rem_m20_3_starts", st, 0);
        do_req(3'b100, 32'd5, 32'd0, 5'd9, d, lat, st);
        chk("div_by_zero", d, 32'hFFFF_FFFF);
        do_req(3'b110, 32'd5, 32'd0, 5'd10, d, lat, st);
        chk("rem_by_zero", d, 32'd5);

        do_req(3'b010, 32'd5, 32'd6, 5'd11, d, lat, st);
        chk("illegal_data", d, 32'd0);
        chk("illegal_lat", lat, 1);
        chk("illegal_starts", st, 0);

        // Flush while the divider is running
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'b100; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd = 5'd12;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 60) begin @(negedge clk); k++; end
        @(posedge clk); #1 req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!dv_busy && k < 20) begin @(negedge clk); k++; end
        chk("flush_div_running", {31'd0, dv_busy}, 32'd1);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        r0 = resp_cnt;
        k = 0;
        @(negedge clk);
        while (!dv_fin && k < 30) begin @(negedge clk); k++; end
        chk("drain_ready_at_fin", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("drain_ready_after", {31'd0, req_ready}, 32'd1);
        chk("flush_no_resp", resp_cnt, r0);
        do_req(3'b100, 32'd1000, 32'd3, 5'd13, d, lat, st);
        chk("after_flush_div", d, 32'd333);
        chk("after_flush_starts", st, 1);

        // Reset in the middle of a divide
        do_req(3'b100, 32'd100, 32'd7, 5'd14, d, lat, st);
        chk("refill_div", d, 32'd14);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'b101; req_rs1 = 32'd77; req_rs2 = 32'd5; req_rd = 5'd15;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("post_rst_div_op", {29'd0, div_op}, 32'd4);
        chk("post_rst_dividend", div_dividend, 32'd0);
        do_req(3'b110, 32'd100, 32'd7, 5'd16, d, lat, st);
        chk("post_rst_rem", d, 32'd2);
        chk("post_rst_starts", st, 1);

        // Request held against flush is never taken
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'b100; req_rs1 = 32'd9; req_rs2 = 32'd2; flush = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_blocks_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;

        // Randomized traffic with operand reuse to exercise the cache
        pool[0] = 32'd0;           pool[1] = 32'd1;           pool[2] = 32'd7;
        pool[3] = 32'd100;         pool[4] = 32'hFFFF_FFFF;   pool[5] = 32'h8000_0000;
        pool[6] = 32'hFFFF_FFEC;   pool[7] = 32'd3;
        la = 32'd100; lb = 32'd7;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 7) == 0) pool[$urandom_range(0, 7)] = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                la = pool[$urandom_range(0, 7)];
                lb = pool[$urandom_range(0, 7)];
            end
            req_valid = ($urandom_range(0, 1) == 0);
            req_op    = {($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3))};
            req_rs1   = la;
            req_rs2   = lb;
            req_rd    = TAG_W'($urandom);
            flush     = ($urandom_range(0, 24) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0; rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
